// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//
// Purpose:
//   Sits between the core's single-cycle combinational data-memory port and a
//   variable-latency data memory using a valid/ready request channel and a
//   valid-only response channel. While a transfer is outstanding the bridge
//   raises core_stall so the core holds its PC and register writes; the core
//   commits on the single DONE cycle, during which core_stall is low.
//
// Parameters:
//   ADDR_W          address width (>= 2)
//   DATA_W          data width
//   TIMEOUT_CYCLES  watchdog limit in cycles (>= 1); only used when the
//                   DMB_TIMEOUT_EN macro is defined
//
// Configuration macro:
//   DMB_TIMEOUT_EN  when defined, a watchdog counter aborts a transfer that
//                   spends TIMEOUT_CYCLES cycles in REQ/WAIT, flagging bus_err
//                   and returning zero read data. When undefined, the bridge
//                   waits indefinitely and bus_err is set only by misalignment.
//
// Ports:
//   clk             in   clock; all state updates on posedge
//   reset           in   asynchronous, active-low reset
//   core_addr       in   data_addr from core
//   core_rd         in   should_read_mem from core
//   core_wr         in   should_write_mem from core
//   core_wdata      in   mem_write_data from core
//   core_rdata      out  registered read data returned to the core
//   core_stall      out  hold core PC and register writes
//   mem_req_valid   out  request valid
//   mem_req_ready   in   memory accepts request
//   mem_req_we      out  1 = write, 0 = read
//   mem_req_addr    out  word-aligned request address
//   mem_req_wdata   out  write data
//   mem_resp_valid  in   response valid; completes both reads and writes
//   mem_resp_data   in   read data; ignored for writes
//   bus_err         out  sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module data_mem_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              we_q,      we_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              bus_err_q, bus_err_d;

  logic core_req;
  logic addr_aligned;
  logic in_flight;

  assign core_req     = core_rd | core_wr;
  assign addr_aligned = (core_addr[1:0] == 2'b00);
  assign in_flight    = (state_q == ST_REQ) || (state_q == ST_WAIT);

`ifdef DMB_TIMEOUT_EN
  // At least 8 bits wide, wider if TIMEOUT_CYCLES needs it.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // The counter holds the number of cycles already spent in REQ/WAIT, so the
  // abort fires on the cycle that completes the TIMEOUT_CYCLES-th one.
  assign timeout_hit = in_flight && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
`ifdef DMB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (core_req) begin
          if (addr_aligned) begin
            // A simultaneous read and write is issued as a write.
            addr_d  = core_addr;
            wdata_d = core_wdata;
            we_d    = core_wr;
            state_d = ST_REQ;
`ifdef DMB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Misaligned access never reaches the bus; complete it at once
            // with an error and zero data.
            bus_err_d = 1'b1;
            rdata_d   = '0;
            state_d   = ST_DONE;
          end
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem_resp_valid) begin
          // Writes complete on the response but leave the read register alone.
          if (!we_q) begin
            rdata_d = mem_resp_data;
          end
          state_d = ST_DONE;
        end
      end

      default: begin
        // ST_DONE: the core commits on this edge.
        state_d = ST_IDLE;
      end
    endcase

`ifdef DMB_TIMEOUT_EN
    if (in_flight) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Watchdog abort overrides any handshake or response in the same cycle.
    if (timeout_hit) begin
      bus_err_d = 1'b1;
      rdata_d   = '0;
      state_d   = ST_DONE;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef DMB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
`ifdef DMB_TIMEOUT_EN
  // Withdraw the request on the abort cycle so no handshake can complete.
  assign mem_req_valid = (state_q == ST_REQ) && !timeout_hit;
`else
  assign mem_req_valid = (state_q == ST_REQ);
`endif

  // The core stalls in the very cycle it issues a request. Gating with reset
  // keeps the output low while reset is held even if the core still requests.
  assign core_stall = reset &&
                      (((state_q == ST_IDLE) && core_req) || in_flight);

  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign core_rdata    = rdata_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_addr;
  logic        core_rd;
  logic        core_wr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        bus_err;

  always #5 clk = ~clk;

  data_mem_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_addr(core_addr),
    .core_rd(core_rd),
    .core_wr(core_wr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .bus_err(bus_err)
  );

  // Expected completion of each transaction: read data and error flag seen
  // by the core on its commit cycle.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge; checks follow 1 unit
  // later so combinational outputs have settled, well before the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic done_check(input string tag);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      $display("txn %s: rdata=%h bus_err=%0b", tag, core_rdata, bus_err);
      chk({tag, "_rdata"}, core_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, e.err});
    end
  endtask

  initial begin
    reset          = 1'b0;
    core_addr      = '0;
    core_rd        = 1'b0;
    core_wr        = 1'b0;
    core_wdata     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // ---------------- reset state ----------------
    repeat (3) step();
    #1;
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_we", mem_req_we, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_wdata", mem_req_wdata, 0);
    reset = 1'b1;

    // ---------------- read, minimum-ish latency ----------------
    step(); core_rd = 1'b1; core_addr = 32'h100;
    sb.push_back({32'hCAFEBABE, 1'b0}); #1;
    chk("rd_c0_stall", core_stall, 1);
    chk("rd_c0_valid", mem_req_valid, 0);
    step(); mem_req_ready = 1'b1; #1;
    chk("rd_c1_valid", mem_req_valid, 1);
    chk("rd_c1_addr", mem_req_addr, 32'h100);
    chk("rd_c1_we", mem_req_we, 0);
    chk("rd_c1_stall", core_stall, 1);
    step(); mem_req_ready = 1'b0; #1;
    chk("rd_c2_valid", mem_req_valid, 0);
    chk("rd_c2_stall", core_stall, 1);
    step(); mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEBABE; #1;
    chk("rd_c3_stall", core_stall, 1);
    step(); mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
    chk("rd_c4_stall", core_stall, 0);
    done_check("read");
    step(); core_rd = 1'b0; #1;
    chk("rd_c5_stall", core_stall, 0);

    // ---------------- write with back-pressure ----------------
    step(); core_wr = 1'b1; core_addr = 32'h204; core_wdata = 32'h12345678;
    sb.push_back({32'hCAFEBABE, 1'b0}); #1;
    chk("wr_c0_stall", core_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("wr_hold_valid", mem_req_valid, 1);
      chk("wr_hold_addr", mem_req_addr, 32'h204);
      chk("wr_hold_wdata", mem_req_wdata, 32'h12345678);
      chk("wr_hold_we", mem_req_we, 1);
      chk("wr_hold_stall", core_stall, 1);
    end
    step(); mem_req_ready = 1'b1; #1;
    chk("wr_acc_valid", mem_req_valid, 1);
    step(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF; #1;
    chk("wr_wait_stall", core_stall, 1);
    step(); mem_resp_valid = 1'b0; #1;
    chk("wr_done_stall", core_stall, 0);
    done_check("write");
    step(); core_wr = 1'b0;

    // ---------------- misaligned read ----------------
    step(); core_rd = 1'b1; core_addr = 32'h101;
    sb.push_back({32'h0, 1'b1}); #1;
    chk("mis_c0_stall", core_stall, 1);
    chk("mis_c0_valid", mem_req_valid, 0);
    step(); #1;
    chk("mis_c1_stall", core_stall, 0);
    chk("mis_c1_valid", mem_req_valid, 0);
    done_check("misaligned");
    step(); core_rd = 1'b0; #1;
    chk("mis_c2_stall", core_stall, 0);
    chk("mis_sticky_err", bus_err, 1);

    // ---------------- rd+wr together, stray response in IDLE ----------------
    step(); mem_resp_valid = 1'b1; mem_resp_data = 32'h55555555; #1;
    chk("stray_stall", core_stall, 0);
    chk("stray_valid", mem_req_valid, 0);
    step(); core_rd = 1'b1; core_wr = 1'b1; core_addr = 32'h300; core_wdata = 32'hA5A5A5A5;
    sb.push_back({32'h0, 1'b1}); #1;
    chk("both_c0_stall", core_stall, 1);
    step(); mem_resp_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk("both_c1_valid", mem_req_valid, 1);
    chk("both_c1_we", mem_req_we, 1);
    chk("both_c1_addr", mem_req_addr, 32'h300);
    chk("both_c1_wdata", mem_req_wdata, 32'hA5A5A5A5);
    step(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h77777777; #1;
    chk("both_c2_stall", core_stall, 1);
    step(); mem_resp_valid = 1'b0; #1;
    chk("both_c3_stall", core_stall, 0);
    done_check("both");
    step(); core_rd = 1'b0; core_wr = 1'b0;

    // ---------------- async reset while request is pending ----------------
    step(); core_rd = 1'b1; core_addr = 32'h400; #1;
    step(); #1;
    chk("rstq_valid_before", mem_req_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("rstq_valid", mem_req_valid, 0);
    chk("rstq_stall", core_stall, 0);
    chk("rstq_err", bus_err, 0);
    chk("rstq_rdata", core_rdata, 0);
    core_rd = 1'b0;
    step(); reset = 1'b1; #1;
    chk("rstq_after_stall", core_stall, 0);
    chk("rstq_after_valid", mem_req_valid, 0);

    // ---------------- async reset in WAIT ----------------
    step(); core_rd = 1'b1; core_addr = 32'h404; #1;
    step(); mem_req_ready = 1'b1; #1;
    chk("rstw_c1_valid", mem_req_valid, 1);
    step(); mem_req_ready = 1'b0; #1;
    chk("rstw_c2_stall", core_stall, 1);
    #1 reset = 1'b0;
    #1;
    chk("rstw_valid", mem_req_valid, 0);
    chk("rstw_stall", core_stall, 0);
    core_rd = 1'b0;
    step(); reset = 1'b1;
    step(); #1;
    chk("rstw_idle_stall", core_stall, 0);
    chk("rstw_idle_valid", mem_req_valid, 0);

    // ---------------- read after reset: fastest legal response ----------------
    step(); core_rd = 1'b1; core_addr = 32'h10;
    sb.push_back({32'h0BADF00D, 1'b0}); #1;
    step(); mem_req_ready = 1'b1; #1;
    chk("rd2_c1_valid", mem_req_valid, 1);
    step(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0BADF00D; #1;
    chk("rd2_c2_stall", core_stall, 1);
    step(); mem_resp_valid = 1'b0; #1;
    chk("rd2_c3_stall", core_stall, 0);
    done_check("read2");
    step(); core_rd = 1'b0;

`ifdef DMB_TIMEOUT_EN
    // ---------------- watchdog: accepted, never answered ----------------
    begin
      int k;
      step(); core_rd = 1'b1; core_addr = 32'h500;
      sb.push_back({32'h0, 1'b1}); #1;
      step(); mem_req_ready = 1'b1; #1;
      chk("to_c1_valid", mem_req_valid, 1);
      for (k = 0; k < 20; k++) begin
        step(); mem_req_ready = 1'b0; #1;
        if (!core_stall) break;
      end
      chk("to_wait_cycles", k, 3);
      done_check("timeout");
      chk("to_valid", mem_req_valid, 0);
      step(); core_rd = 1'b0;
    end
`endif

    step(); #1;
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
